// File: rtl/ioapic_msi_pkg.sv
// Shared types and MSI formatting helpers for the IOAPIC MSI transmit stage.
package ioapic_msi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } msi_state_t;

   localparam logic [31:0] MSI_BASE_ADDR = 32'hFEE0_0000;
   localparam logic [1:0]  BRESP_OKAY    = 2'b00;

   typedef struct packed {
      logic [7:0] vector;
      logic [7:0] dest;
      logic [2:0] deliv_mode;
   } msi_msg_t;

   // Physical destination mode, no redirection hint: RH/DM bits stay 0.
   function automatic logic [31:0] msi_addr_f(input logic [7:0] dest);
      return MSI_BASE_ADDR | {12'h000, dest, 12'h000};
   endfunction

   // Edge-triggered, deassert level: trigger and level bits stay 0.
   function automatic logic [31:0] msi_data_f(input msi_msg_t m);
      return {16'h0000, 1'b0, 1'b0, 3'b000, m.deliv_mode, m.vector};
   endfunction

endpackage

// File: rtl/ioapic_msi_fifo.sv
// Synchronous FIFO of delivery requests with registered level and full flag.
module ioapic_msi_fifo
   import ioapic_msi_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  msi_msg_t                   data_i,
   input  logic                       pop_i,
   output msi_msg_t                   head_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [$clog2(DEPTH):0]     level_nxt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [AW-1:0] wptr_q, rptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          full_q;
   logic          do_push, do_pop;
   msi_msg_t      mem_q [DEPTH];

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && (level_q != '0);

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
      end
   end

   // NOTE: storage has no reset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   assign head_o      = mem_q[rptr_q];
   assign empty_o     = (level_q == '0);
   assign full_o      = full_q;
   assign level_o     = level_q;
   assign level_nxt_o = level_d;

endmodule

// File: rtl/ioapic_msi_tx.sv
// IOAPIC MSI transmitter: buffers delivery requests, issues MSI writes with bounded retry,
// forwards LAPIC EOIs. Optional response timeout enabled by IOAPIC_MSI_TIMEOUT_EN.
module ioapic_msi_tx
   import ioapic_msi_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int MAX_RETRY      = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   input  logic [7:0]                    req_vector,
   input  logic [7:0]                    req_dest,
   input  logic [2:0]                    req_deliv_mode,
   output logic                          req_ready,
   output logic                          msi_awvalid,
   output logic [31:0]                   msi_addr,
   output logic [31:0]                   msi_data,
   input  logic                          msi_awready,
   input  logic                          msi_bvalid,
   input  logic [1:0]                    msi_bresp,
   output logic                          msi_bready,
   input  logic                          lapic_eoi_valid,
   input  logic [7:0]                    lapic_eoi_vector,
   output logic                          eoi_out,
   output logic [7:0]                    eoi_vector,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [7:0]                    drop_count,
   output logic                          busy
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int RW = $clog2(MAX_RETRY + 2);

   msi_state_t    state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [7:0]    drop_q, drop_d;
   logic          busy_q, busy_d;
   logic          eoi_q;
   logic [7:0]    eoi_vec_q;

   msi_msg_t      push_msg, head_msg;
   logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [LW-1:0] fifo_level_q, fifo_level_nxt;
   logic          rsp_err;
   logic          tmo_hit;

   assign push_msg  = '{vector: req_vector, dest: req_dest, deliv_mode: req_deliv_mode};
   assign fifo_push = req_valid && req_ready;

   ioapic_msi_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (fifo_push),
      .data_i      (push_msg),
      .pop_i       (fifo_pop),
      .head_o      (head_msg),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .level_o     (fifo_level_q),
      .level_nxt_o (fifo_level_nxt)
   );

`ifdef IOAPIC_MSI_TIMEOUT_EN
   logic [15:0] tmo_q, tmo_d;

   // Counter only advances while waiting in RESP; any other state restarts it.
   assign tmo_d   = (state_q == RESP && !msi_bvalid) ? tmo_q + 16'd1 : 16'd0;
   assign tmo_hit = (state_q == RESP) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= 16'd0;
      else        tmo_q <= tmo_d;
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_hit        = 1'b0;
`endif

   // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      retry_d  = retry_q;
      drop_d   = drop_q;
      fifo_pop = 1'b0;
      rsp_err  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               addr_d   = msi_addr_f(head_msg.dest);
               data_d   = msi_data_f(head_msg);
               fifo_pop = 1'b1;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            if (msi_awready) state_d = RESP;
         end
         RESP: begin
            // A real response always takes precedence over a coincident timeout.
            if (msi_bvalid) begin
               if (msi_bresp == BRESP_OKAY) begin
                  retry_d = '0;
                  state_d = IDLE;
               end else begin
                  rsp_err = 1'b1;
               end
            end else if (tmo_hit) begin
               rsp_err = 1'b1;
            end

            if (rsp_err) begin
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  state_d = ADDR;
               end else begin
                  drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                  retry_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE) || (fifo_level_nxt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         retry_q   <= '0;
         drop_q    <= '0;
         busy_q    <= 1'b0;
         eoi_q     <= 1'b0;
         eoi_vec_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         retry_q   <= retry_d;
         drop_q    <= drop_d;
         busy_q    <= busy_d;
         eoi_q     <= lapic_eoi_valid;
         eoi_vec_q <= lapic_eoi_vector;
      end
   end

   assign req_ready   = !fifo_full;
   assign msi_awvalid = (state_q == ADDR);
   assign msi_bready  = (state_q == RESP);
   assign msi_addr    = addr_q;
   assign msi_data    = data_q;
   assign eoi_out     = eoi_q;
   assign eoi_vector  = eoi_vec_q;
   assign fifo_level  = fifo_level_q;
   assign drop_count  = drop_q;
   assign busy        = busy_q;

endmodule
